// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b datapath constants for the pipeline stage chain
package lc3b_types;

    localparam int PIPE_IF_ID  = 0;
    localparam int PIPE_ID_EX  = 1;
    localparam int PIPE_EX_MEM = 2;
    localparam int PIPE_MEM_WB = 3;

    localparam int PIPE_STAGES_DEFAULT = 4;
    localparam int PIPE_WIDTH_DEFAULT  = 64;
    localparam int PIPE_CNT_W_DEFAULT  = 16;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// rtl/pipe_stage_chain_if.sv - fetch handshake, stall/flush controls and stage observation bundle
interface pipe_stage_chain_if
    import lc3b_types::*;
#(
    parameter int STAGES = PIPE_STAGES_DEFAULT,
    parameter int WIDTH  = PIPE_WIDTH_DEFAULT,
    parameter int CNT_W  = PIPE_CNT_W_DEFAULT
);
    logic                           in_valid;
    logic [WIDTH-1:0]               in_data;
    logic                           in_ready;
    logic [STAGES-1:0]              stall_req;
    logic [STAGES-1:0]              flush;
    logic [STAGES-1:0]              stage_valid;
    logic [STAGES-1:0][WIDTH-1:0]   stage_data;
    logic [CNT_W-1:0]               stall_cycles;

    modport master (
        output in_valid, in_data, stall_req, flush,
        input  in_ready, stage_valid, stage_data, stall_cycles
    );

    modport slave (
        input  in_valid, in_data, stall_req, flush,
        output in_ready, stage_valid, stage_data, stall_cycles
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one pipeline latch: valid bit plus payload with flush/hold/bubble control
module pipe_stage_reg
    import lc3b_types::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic             bubble,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Payload only loads with a valid item, so killed slots keep their last data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (hold) begin
            valid <= valid;
        end else if (bubble) begin
            valid <= 1'b0;
        end else begin
            valid <= in_valid;
            if (in_valid) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - stallable/flushable chain of pipeline latches with stall-cycle counter
module pipe_stage_chain
    import lc3b_types::*;
#(
    parameter int STAGES = PIPE_STAGES_DEFAULT,
    parameter int WIDTH  = PIPE_WIDTH_DEFAULT,
    parameter int CNT_W  = PIPE_CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_chain_if.slave    bus
);

    logic [STAGES-1:0]            hold;
    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0][WIDTH-1:0] data_q;
    logic [CNT_W-1:0]             cnt_q;

    // A stall anywhere downstream freezes every stage upstream of it.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc     = acc | bus.stall_req[i];
            hold[i] = acc;
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             up_bubble;

        if (i == 0) begin : g_head
            assign up_valid  = bus.in_valid;
            assign up_data   = bus.in_data;
            assign up_bubble = 1'b0;
        end else begin : g_body
            assign up_valid  = valid_q[i-1];
            assign up_data   = data_q[i-1];
            assign up_bubble = hold[i-1];
        end

        pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
            .clk      (clk),
            .rst      (rst),
            .flush    (bus.flush[i]),
            .hold     (hold[i]),
            .bubble   (up_bubble),
            .in_valid (up_valid),
            .in_data  (up_data),
            .valid    (valid_q[i]),
            .data     (data_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (|bus.stall_req && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready     = ~hold[0];
    assign bus.stage_valid  = valid_q;
    assign bus.stage_data   = data_q;
    assign bus.stall_cycles = cnt_q;

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised chain of pipeline stage registers with per-entry valid bits, per-stage stall (hold plus bubble insertion) and per-stage flush. It replaces the free-running IF/ID, ID/EX, EX/MEM and MEM/WB latches of the LC-3b pipelined datapath, so hazard and branch logic can freeze or kill stages instead of loading every clock. It also provides a saturating stall-cycle counter for performance measurement.

## Interface
- STAGES, default 4: number of stage registers. Index 0 is IF/ID; index STAGES-1 is MEM/WB.
- WIDTH, default 64: payload bits per stage (IR, PC, control word, operands as packed by the datapath).
- CNT_W, default 16: stall counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the fetch side presents an instruction.
- in_data  in  WIDTH  payload entering stage 0.
- in_ready  out  1  stage 0 accepts this cycle; equals ~hold[0].
- stall_req  in  STAGES  bit k: register k's contents cannot advance this cycle.
- flush  in  STAGES  bit k: register k must be invalid next cycle.
- stage_valid  out  STAGES  valid bit of each register.
- stage_data  out  [STAGES][WIDTH]  payload of each register.
- stall_cycles  out  CNT_W  count of cycles with any stall_req bit set.

## Operation
- hold[i] = OR of stall_req[j] for all j ≥ i. A stall freezes that stage and every upstream stage.
- Per-register next state, evaluated in priority order:
  - flush[i]: valid ← 0; data unchanged. Flush overrides hold.
  - hold[i]: valid and data unchanged.
  - i = 0, not held: valid ← in_valid; data ← in_data only if in_valid.
  - i > 0, not held, hold[i-1] set: this is a bubble. valid ← 0; data unchanged.
  - i > 0, not held, hold[i-1] clear: valid ← valid[i-1]; data ← data[i-1] only if valid[i-1].
- Flush kills what register i would hold next cycle. Register i-1's current contents still move into register i unless flush[i] is set.
- flush[0] with in_valid and in_ready: the input is consumed and discarded.
- stall_cycles increments when |stall_req. It saturates at all-ones, with no wrap.
- There is no internal hazard detection. Stall and flush policy belongs to the caller.

## Timing
- Reset: stage_valid = 0, stage_data = 0, stall_cycles = 0, in_ready = 1 once rst is low with no stall.
- Latency: an accepted item appears in register k exactly k+1 cycles after acceptance, provided there are no stalls.
- in_ready is combinational from stall_req. There is no path from in_valid to in_ready.
- Flush and stall in the same cycle on different stages:
  - Flushed registers go invalid.
  - Held registers that are not flushed keep their contents.
  - The first non-held register downstream of a stall receives a bubble.
- rst asserted mid-stall or mid-flush clears all state on that edge, regardless of other inputs.
- Throughput is one item per cycle when no stall is asserted.

## Structure
- Shared package lc3b_types:
  - Add stage index constants PIPE_IF_ID=0, PIPE_ID_EX=1, PIPE_EX_MEM=2, PIPE_MEM_WB=3.
  - Add a default payload-width constant.
- Sub-module pipe_stage_reg: one register holding valid plus WIDTH data, with inputs flush, hold, bubble, in_valid and in_data. It is instantiated STAGES times in a generate loop.
- The hold prefix-OR and the counter live in the top module.

## Test plan
- **Streaming:** reset, then feed payloads 0x1, 0x2, 0x3, 0x4 on consecutive cycles with no stall. Required: stage 3 shows 0x1..0x4 on cycles 4..7, all valid; stall_cycles = 0.
- **Stall at stage 1 for 2 cycles with 4 items in flight:**
  - stage_valid[0] and stage_valid[1] and their data are frozen.
  - in_ready = 0.
  - stage_valid[2] = 0 (bubble) for 2 cycles, and stage_data[2] keeps its old value.
  - stall_cycles = 2.
- **Branch flush:** flush = 4'b0111 while streaming 0xA..0xD. Required: next cycle stage_valid[2:0] = 0 and stage 3 holds the item that was in register 2. Refill then resumes normally.
- **Flush and hold together:** stall_req[1] = 1 and flush[1] = 1 in the same cycle. Required:
  - register 1 becomes invalid;
  - register 0 is held;
  - register 2 is a bubble.
- **Counter saturation:** with CNT_W = 4, hold stall_req[3] for 20 cycles. Required: stall_cycles stops at 0xF.
- **Reset mid-operation:** assert rst during an active stall with all stages valid. Required: all valid bits 0, data 0, counter 0 on the next edge.
